// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the miner slave register block: Avalon-MM word
// addresses, CTRL bit positions, message/target widths, the message-commit
// FSM state type and helpers that locate a staging word inside the packed
// message and target vectors.
// -----------------------------------------------------------------------------
package miner_pkg;

    localparam int MSG_W = 408;
    localparam int TGT_W = 256;

    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_STATUS = 5'd1;
    localparam logic [4:0] ADDR_NONCE  = 5'd2;
    localparam logic [4:0] ADDR_MSG_LO = 5'd3;
    localparam logic [4:0] ADDR_MSG_HI = 5'd15;
    localparam logic [4:0] ADDR_TGT_LO = 5'd16;
    localparam logic [4:0] ADDR_TGT_HI = 5'd23;

    localparam int CTRL_TGT_COMMIT = 0;
    localparam int CTRL_MSG_COMMIT = 1;
    localparam int CTRL_CLR_FOUND  = 2;

    typedef enum logic [1:0] {
        MSG_IDLE   = 2'd0,
        MSG_WAIT   = 2'd1,
        MSG_COMMIT = 2'd2,
        MSG_PULSE  = 2'd3
    } msg_state_t;

    // LSB of the full 32-bit message word held at addresses 4..15.
    // Address 3 is the short 24-bit tail at message[23:0], so word 4 starts
    // at bit 24 and each higher address sits 32 bits above.
    function automatic logic [8:0] msg_word_lsb(input logic [4:0] addr);
        logic [8:0] idx;
        idx = {4'd0, addr} - 9'd4;
        return (idx << 5) + 9'd24;
    endfunction

    // LSB of the target word held at addresses 16..23.
    function automatic logic [7:0] tgt_word_lsb(input logic [4:0] addr);
        logic [7:0] idx;
        idx = {3'd0, addr} - 8'd16;
        return idx << 5;
    endfunction

endpackage

// File: rtl/msg_commit_fsm.sv
// -----------------------------------------------------------------------------
// msg_commit_fsm
// Sequences a message commit: a request waits until the hashing core is idle,
// then a one-cycle load strobe copies staging into the message register,
// followed by a one-cycle newMsg pulse. Requests arriving while a commit is
// in flight collapse into a single pending bit served on return to IDLE.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_req           one-cycle commit request (CTRL bit1 write)
//   i_miner_busy    hashing core busy; commit is held off while set
//   o_load          high during COMMIT; top copies staging on this edge
//   o_new_msg       high during PULSE (exactly one cycle)
//   o_active        a commit is pending or in progress
// -----------------------------------------------------------------------------
module msg_commit_fsm
    import miner_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_miner_busy,
    output logic o_load,
    output logic o_new_msg,
    output logic o_active
);

    msg_state_t r_state;
    msg_state_t w_next;
    logic       r_pending;
    logic       w_pending_next;
    logic       r_load;
    logic       r_new_msg;

    // Next-state and pending-request logic.
    always_comb begin
        w_next         = r_state;
        w_pending_next = r_pending;
        case (r_state)
            MSG_IDLE: begin
                if (i_req || r_pending) begin
                    w_next = MSG_WAIT;
                end else begin
                    w_next = MSG_IDLE;
                end
            end
            MSG_WAIT: begin
                if (i_miner_busy) begin
                    w_next = MSG_WAIT;
                end else begin
                    w_next = MSG_COMMIT;
                end
            end
            MSG_COMMIT: w_next = MSG_PULSE;
            MSG_PULSE:  w_next = MSG_IDLE;
            default:    w_next = MSG_IDLE;
        endcase
        // In IDLE a request (new or pending) is consumed directly by the move
        // to WAIT; anywhere else it is parked, merging with any earlier one.
        if (r_state == MSG_IDLE) begin
            w_pending_next = 1'b0;
        end else begin
            w_pending_next = r_pending | i_req;
        end
    end

    // State, pending bit and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= MSG_IDLE;
            r_pending <= 1'b0;
            r_load    <= 1'b0;
            r_new_msg <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_pending_next;
            r_load    <= (w_next == MSG_COMMIT);
            r_new_msg <= (w_next == MSG_PULSE);
        end
    end

    assign o_load    = r_load;
    assign o_new_msg = r_new_msg;
    assign o_active  = r_pending | (r_state != MSG_IDLE);

endmodule

// File: rtl/miner_slave_regs.sv
// -----------------------------------------------------------------------------
// miner_slave_regs
// Avalon-MM register slave for a bitcoin hashing core. Software fills
// message/target staging registers, then commits them through CTRL. Target
// commits are immediate; message commits wait for the core to go idle
// (msg_commit_fsm). A found flag and nonce capture results from the core.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   slaveAddr/WriteData/Write/Read/ChipSelect   Avalon-MM slave request
//   slaveReadData                  read data, one cycle after the read
//   minerBusy, validBTC, foundNonce   status/results from the hashing core
//   target, message                committed values driven to the core
//   newTarget, newMsg              one-cycle commit notifications
// -----------------------------------------------------------------------------
module miner_slave_regs
    import miner_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       slaveAddr,
    input  logic [31:0]      slaveWriteData,
    input  logic             slaveWrite,
    input  logic             slaveRead,
    input  logic             slaveChipSelect,
    output logic [31:0]      slaveReadData,
    input  logic             minerBusy,
    input  logic             validBTC,
    input  logic [31:0]      foundNonce,
    output logic [TGT_W-1:0] target,
    output logic [MSG_W-1:0] message,
    output logic             newTarget,
    output logic             newMsg
);

    logic [MSG_W-1:0] r_msg_stage;
    logic [TGT_W-1:0] r_tgt_stage;
    logic [MSG_W-1:0] r_message;
    logic [TGT_W-1:0] r_target;
    logic             r_tgt_copied;
    logic             r_new_target;
    logic [31:0]      r_nonce;
    logic             r_found;
    logic [31:0]      r_read_data;

    logic             w_wr;
    logic             w_rd;
    logic             w_ctrl_wr;
    logic             w_msg_tail_hit;
    logic             w_msg_word_hit;
    logic             w_tgt_hit;
    logic             w_fsm_load;
    logic             w_fsm_new_msg;
    logic             w_fsm_active;
    logic [31:0]      w_rd_mux;

    assign w_wr           = slaveWrite & slaveChipSelect;
    assign w_rd           = slaveRead & slaveChipSelect;
    assign w_ctrl_wr      = w_wr && (slaveAddr == ADDR_CTRL);
    assign w_msg_tail_hit = (slaveAddr == ADDR_MSG_LO);
    assign w_msg_word_hit = (slaveAddr > ADDR_MSG_LO) && (slaveAddr <= ADDR_MSG_HI);
    assign w_tgt_hit      = (slaveAddr >= ADDR_TGT_LO) && (slaveAddr <= ADDR_TGT_HI);

    msg_commit_fsm u_msg_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_req        (w_ctrl_wr && slaveWriteData[CTRL_MSG_COMMIT]),
        .i_miner_busy (minerBusy),
        .o_load       (w_fsm_load),
        .o_new_msg    (w_fsm_new_msg),
        .o_active     (w_fsm_active)
    );

    // Staging registers; the message tail at address 3 keeps only bits 31:8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg_stage <= '0;
            r_tgt_stage <= '0;
        end else begin
            if (w_wr && w_msg_tail_hit) begin
                r_msg_stage[23:0] <= slaveWriteData[31:8];
            end else if (w_wr && w_msg_word_hit) begin
                r_msg_stage[msg_word_lsb(slaveAddr) +: 32] <= slaveWriteData;
            end
            if (w_wr && w_tgt_hit) begin
                r_tgt_stage[tgt_word_lsb(slaveAddr) +: 32] <= slaveWriteData;
            end
        end
    end

    // Target commit: copy on the CTRL write edge, notify one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target     <= '0;
            r_tgt_copied <= 1'b0;
            r_new_target <= 1'b0;
        end else begin
            if (w_ctrl_wr && slaveWriteData[CTRL_TGT_COMMIT]) begin
                r_target <= r_tgt_stage;
            end
            r_tgt_copied <= w_ctrl_wr && slaveWriteData[CTRL_TGT_COMMIT];
            r_new_target <= r_tgt_copied;
        end
    end

    // Message register, loaded from staging while the FSM is in COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_message <= '0;
        end else if (w_fsm_load) begin
            r_message <= r_msg_stage;
        end
    end

    // Found flag and nonce; a result from the core beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_found <= 1'b0;
            r_nonce <= 32'd0;
        end else if (validBTC) begin
            r_found <= 1'b1;
            r_nonce <= foundNonce;
        end else if ((w_ctrl_wr && slaveWriteData[CTRL_CLR_FOUND]) || w_fsm_load) begin
            r_found <= 1'b0;
        end
    end

    // Read-back multiplexer over current (pre-write) register contents.
    always_comb begin
        w_rd_mux = 32'd0;
        if (slaveAddr == ADDR_STATUS) begin
            w_rd_mux = {29'd0, w_fsm_active, r_found, minerBusy};
        end else if (slaveAddr == ADDR_NONCE) begin
            w_rd_mux = r_nonce;
        end else if (w_msg_tail_hit) begin
            w_rd_mux = {r_msg_stage[23:0], 8'd0};
        end else if (w_msg_word_hit) begin
            w_rd_mux = r_msg_stage[msg_word_lsb(slaveAddr) +: 32];
        end else if (w_tgt_hit) begin
            w_rd_mux = r_tgt_stage[tgt_word_lsb(slaveAddr) +: 32];
        end else begin
            w_rd_mux = 32'd0;
        end
    end

    // Read data register; holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= 32'd0;
        end else if (w_rd) begin
            r_read_data <= w_rd_mux;
        end
    end

    assign slaveReadData = r_read_data;
    assign target        = r_target;
    assign message       = r_message;
    assign newTarget     = r_new_target;
    assign newMsg        = w_fsm_new_msg;

endmodule

// File: tb/tb_miner_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_miner_slave_regs
// Scoreboard bench: bus reads push the model's expected word into a queue and
// a negedge monitor pops/compares when read data becomes valid. The model
// keeps staging as a plain word array indexed by bus address and rebuilds
// message/target by shifting words in from the most significant address.
// -----------------------------------------------------------------------------
module tb_miner_slave_regs;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4:0]     slaveAddr = 5'd0;
    logic [31:0]    slaveWriteData = 32'd0;
    logic           slaveWrite = 1'b0;
    logic           slaveRead = 1'b0;
    logic           slaveChipSelect = 1'b0;
    logic [31:0]    slaveReadData;
    logic           minerBusy = 1'b0;
    logic           validBTC = 1'b0;
    logic [31:0]    foundNonce = 32'd0;
    logic [255:0]   target;
    logic [407:0]   message;
    logic           newTarget;
    logic           newMsg;

    miner_slave_regs dut (
        .clk             (clk),
        .rst             (rst),
        .slaveAddr       (slaveAddr),
        .slaveWriteData  (slaveWriteData),
        .slaveWrite      (slaveWrite),
        .slaveRead       (slaveRead),
        .slaveChipSelect (slaveChipSelect),
        .slaveReadData   (slaveReadData),
        .minerBusy       (minerBusy),
        .validBTC        (validBTC),
        .foundNonce      (foundNonce),
        .target          (target),
        .message         (message),
        .newTarget       (newTarget),
        .newMsg          (newMsg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_new_tgt = 0;
    int n_new_msg = 0;
    int last_tgt_cyc = -1;
    int exp_tgt_cyc = -2;
    logic rd_fire_d = 1'b0;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_a_q[$];

    // reference model state
    logic [31:0]  m_stage [0:31];
    logic [255:0] m_target;
    logic [407:0] m_message;
    logic [31:0]  m_nonce;
    logic         m_found;
    logic         m_active;

    task automatic check(input string name, input logic [407:0] act, input logic [407:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_fire_d <= slaveRead & slaveChipSelect & ~rst;
    end

    // monitor: pulse counting and read-data scoreboard
    always @(negedge clk) begin
        if (newTarget) begin
            n_new_tgt++;
            last_tgt_cyc = cyc;
        end
        if (newMsg) n_new_msg++;
        if (rd_fire_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no read", slaveReadData);
            end else begin
                check($sformatf("rd_addr%0d", exp_a_q.pop_front()), 408'(slaveReadData), 408'(exp_q.pop_front()));
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < 32; i++) m_stage[i] = 32'd0;
        m_target  = '0;
        m_message = '0;
        m_nonce   = 32'd0;
        m_found   = 1'b0;
        m_active  = 1'b0;
    endtask

    function automatic logic [407:0] model_msg();
        logic [407:0] m;
        m = '0;
        for (int a = 15; a >= 4; a--) m = (m << 32) | 408'(m_stage[a]);
        m = (m << 24) | 408'(m_stage[3] >> 8);
        return m;
    endfunction

    function automatic logic [255:0] model_tgt();
        logic [255:0] t;
        t = '0;
        for (int a = 23; a >= 16; a--) t = (t << 32) | 256'(m_stage[a]);
        return t;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd1) return {29'd0, m_active, m_found, minerBusy};
        if (a == 5'd2) return m_nonce;
        if (a >= 5'd3 && a <= 5'd23) return m_stage[a];
        return 32'd0;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd3) begin
            m_stage[3] = d & 32'hFFFF_FF00;
        end else if (a >= 5'd4 && a <= 5'd23) begin
            m_stage[a] = d;
        end else if (a == 5'd0) begin
            if (d[0]) begin
                m_target    = model_tgt();
                exp_tgt_cyc = cyc + 1;
            end
            if (d[2]) m_found = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic cs);
        slaveAddr = a; slaveWriteData = d; slaveWrite = 1'b1; slaveChipSelect = cs;
        tick();
        slaveWrite = 1'b0; slaveChipSelect = 1'b0;
        if (cs) model_write(a, d);
    endtask

    task automatic bus_read(input logic [4:0] a);
        exp_q.push_back(model_read(a));
        exp_a_q.push_back(a);
        slaveAddr = a; slaveRead = 1'b1; slaveChipSelect = 1'b1;
        tick();
        slaveRead = 1'b0; slaveChipSelect = 1'b0;
    endtask

    task automatic bus_rw(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back(model_read(a));
        exp_a_q.push_back(a);
        slaveAddr = a; slaveWriteData = d; slaveRead = 1'b1; slaveWrite = 1'b1; slaveChipSelect = 1'b1;
        tick();
        slaveRead = 1'b0; slaveWrite = 1'b0; slaveChipSelect = 1'b0;
        model_write(a, d);
    endtask

    task automatic pulse_valid(input logic [31:0] n);
        validBTC = 1'b1; foundNonce = n;
        tick();
        validBTC = 1'b0;
        m_nonce = n;
        m_found = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        logic seen;
        reset_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_target", 408'(target), 408'd0);
        check("reset_message", message, 408'd0);
        check("reset_readdata", 408'(slaveReadData), 408'd0);
        check("reset_newTarget", 408'(newTarget), 408'd0);
        check("reset_newMsg", 408'(newMsg), 408'd0);
        rst = 1'b0;
        tick();

        // unselected write is ignored; unused and staging addresses read 0
        bus_write(5'd27, 32'h1234_5678, 1'b0);
        bus_read(5'd27);
        bus_read(5'd3);

        // randomized register traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: bus_write(5'($urandom_range(1, 31)), $urandom, ($urandom_range(0, 3) != 0));
                1: bus_read(5'($urandom_range(0, 31)));
                2: pulse_valid($urandom);
                3: bus_rw(5'($urandom_range(1, 31)), $urandom);
                default: begin
                    slaveAddr = 5'($urandom_range(0, 31)); slaveRead = 1'b1; slaveChipSelect = 1'b0;
                    tick();
                    slaveRead = 1'b0;
                end
            endcase
        end
        bus_write(5'd0, 32'd4, 1'b1);
        bus_read(5'd1);

        // target commit
        base = n_new_tgt;
        bus_write(5'd23, 32'h0FFF_FFFF, 1'b1);
        for (int a = 22; a >= 16; a--) bus_write(5'(a), 32'hFFFF_FFFF, 1'b1);
        bus_write(5'd0, 32'd1, 1'b1);
        repeat (3) tick();
        check("target_value", 408'(target), 408'({4'h0, {252{1'b1}}}));
        check("target_model", 408'(target), 408'(m_target));
        check("newTarget_count", 408'(n_new_tgt - base), 408'd1);
        check("newTarget_cycle", 408'(last_tgt_cyc), 408'(exp_tgt_cyc));
        bus_read(5'd23);

        // message commit with core idle
        minerBusy = 1'b0;
        bus_write(5'd15, 32'h6100_0000, 1'b1);
        for (int a = 14; a >= 3; a--) bus_write(5'(a), 32'd0, 1'b1);
        base = n_new_msg;
        bus_write(5'd0, 32'd2, 1'b1);
        repeat (4) tick();
        m_message = model_msg();
        m_found = 1'b0;
        check("message_a", message, {8'h61, 400'd0});
        check("message_model", message, m_message);
        check("newMsg_count_idle", 408'(n_new_msg - base), 408'd1);
        bus_read(5'd1);

        // found / nonce capture; set wins over clear
        pulse_valid(32'hDEAD_BEEF);
        bus_read(5'd2);
        bus_read(5'd1);
        validBTC = 1'b1; foundNonce = 32'hCAFE_F00D;
        slaveAddr = 5'd0; slaveWriteData = 32'd4; slaveWrite = 1'b1; slaveChipSelect = 1'b1;
        tick();
        validBTC = 1'b0; slaveWrite = 1'b0; slaveChipSelect = 1'b0;
        m_nonce = 32'hCAFE_F00D;
        m_found = 1'b1;
        bus_read(5'd1);
        bus_read(5'd2);

        // commit held off by minerBusy; staging changed while waiting
        minerBusy = 1'b1;
        tick();
        base = n_new_msg;
        bus_write(5'd0, 32'd2, 1'b1);
        m_active = 1'b1;
        repeat (5) tick();
        check("newMsg_while_busy", 408'(n_new_msg - base), 408'd0);
        bus_read(5'd1);
        bus_write(5'd15, 32'h6200_0000, 1'b1);
        minerBusy = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (newMsg) seen = 1'b1;
        end
        check("newMsg_after_busy_drop", 408'(seen), 408'd1);
        repeat (3) tick();
        m_message = model_msg();
        m_found = 1'b0;
        m_active = 1'b0;
        check("message_late_staging", message, m_message);
        check("newMsg_count_busy", 408'(n_new_msg - base), 408'd1);
        bus_read(5'd1);

        // requests during WAIT merge into one pending commit
        minerBusy = 1'b1;
        base = n_new_msg;
        bus_write(5'd0, 32'd2, 1'b1);
        bus_write(5'd0, 32'd2, 1'b1);
        bus_write(5'd0, 32'd2, 1'b1);
        m_active = 1'b1;
        repeat (3) tick();
        bus_read(5'd1);
        minerBusy = 1'b0;
        repeat (12) tick();
        m_active = 1'b0;
        m_message = model_msg();
        m_found = 1'b0;
        check("newMsg_count_merged", 408'(n_new_msg - base), 408'd2);
        bus_read(5'd1);
        repeat (2) tick();

        // reset during WAIT aborts the commit
        minerBusy = 1'b1;
        bus_write(5'd0, 32'd2, 1'b1);
        repeat (2) tick();
        base = n_new_msg;
        rst = 1'b1;
        repeat (2) tick();
        check("rst_target", 408'(target), 408'd0);
        check("rst_message", message, 408'd0);
        check("rst_readdata", 408'(slaveReadData), 408'd0);
        check("rst_newMsg", 408'(newMsg), 408'd0);
        check("rst_newTarget", 408'(newTarget), 408'd0);
        reset_model();
        minerBusy = 1'b0;
        rst = 1'b0;
        repeat (8) tick();
        check("newMsg_after_rst", 408'(n_new_msg - base), 408'd0);
        bus_read(5'd1);
        bus_read(5'd15);
        bus_read(5'd2);

        repeat (3) tick();
        check("scoreboard_drained", 408'(exp_q.size()), 408'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miner_slave_regs.md
MINER_SLAVE_REGS -- requirements
Module: miner_slave_regs

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 slaveAddr  in  5  Avalon-MM word address.
REQ-004 slaveWriteData  in  32  write data.
REQ-005 slaveWrite  in  1  write strobe; qualified by slaveChipSelect.
REQ-006 slaveRead  in  1  read strobe; qualified by slaveChipSelect.
REQ-007 slaveChipSelect  in  1  slave select; transfers without it are ignored.
REQ-008 slaveReadData  out  32  registered read data.
REQ-009 minerBusy  in  1  hashing core is busy with the current message.
REQ-010 validBTC  in  1  one-cycle pulse: the core found a hash at or below the target.
REQ-011 foundNonce  in  32  nonce that accompanies validBTC.
REQ-012 target  out  256  committed target.
REQ-013 message  out  408  committed message.
REQ-014 newTarget  out  1  one-cycle pulse after a target commit.
REQ-015 newMsg  out  1  one-cycle pulse after a message commit.

Function
REQ-016 Address map: 0 CTRL (write); 1 STATUS (read); 2 NONCE (read); 3-15 message staging; 16-23 target staging.
REQ-017 Staging: addr 15 holds message[407:376], descending in 32-bit steps; addr 3 holds message[23:0] in bits 31:8, and bits 7:0 are discarded.
REQ-018 Staging: addr 23 holds target[255:224], descending; addr 16 holds target[31:0].
REQ-019 A staging write changes only staging; the target and message outputs hold until commit.
REQ-020 CTRL bit0=1: copy target staging to target next cycle; newTarget pulses the cycle after that copy; the commit is not gated by minerBusy.
REQ-021 CTRL bit1=1: message commit request, handled by the FSM (REQ-023, REQ-024).
REQ-022 CTRL bit2=1: clear the found flag.
REQ-023 Message FSM states: IDLE, WAIT, COMMIT, PULSE.
REQ-024 Message FSM transitions:
- IDLE to WAIT on a bit1 request.
- WAIT to COMMIT when minerBusy=0; WAIT holds while minerBusy=1.
- COMMIT loads the message register, then goes to PULSE.
- PULSE asserts newMsg for exactly 1 cycle, then returns to IDLE.
REQ-025 A bit1 request arriving outside IDLE is recorded in a single-deep pending bit; it is served on return to IDLE, and further requests merge into it.
REQ-026 A message commit copies the staging contents present at COMMIT, not at request time.
REQ-027 On validBTC=1: foundNonce is latched into NONCE and found is set.
REQ-028 The found flag is cleared by CTRL bit2 and by message COMMIT.
REQ-029 If validBTC coincides with a clear, set wins and NONCE updates.
REQ-030 STATUS = {29'b0, pending|FSM!=IDLE, found, minerBusy}.
REQ-031 Read latency is 1 cycle: slaveReadData is valid the cycle after slaveRead&slaveChipSelect and holds until the next read.
REQ-032 Staging and target addresses read back the staging value; CTRL and addresses 24-31 read as 0.
REQ-033 Writes to STATUS, NONCE or addresses 24-31 are ignored.
REQ-034 A simultaneous read and write at one address returns the pre-write value.

Reset
REQ-035 rst=1 immediately clears all of the following to 0 and places the FSM in IDLE: staging, target, message, NONCE, found, pending, newTarget, newMsg, slaveReadData.
REQ-036 Reset during WAIT or PULSE aborts the commit; no newMsg pulse follows the release of rst.

Structure
REQ-037 Shared package miner_pkg holds:
- address constants ADDR_CTRL, ADDR_STATUS, ADDR_NONCE, ADDR_MSG_LO/HI, ADDR_TGT_LO/HI;
- CTRL bit positions;
- the FSM state enum;
- widths MSG_W=408 and TGT_W=256.
REQ-038 One sub-module, msg_commit_fsm, implements REQ-023 to REQ-026; the register file stays in the top level.

Verification
REQ-039 Write 0x0FFFFFFF then 0xFFFFFFFF to addrs 23..16, then CTRL=1 -> target=256'h0FFF...F; exactly one newTarget pulse 2 cycles after the CTRL write.
REQ-040 Write the message "a" (0x61 in msg[407:400]) to addrs 15..3, then CTRL=2 with minerBusy=0 -> message[407:400]=8'h61 with the remaining bits 0; newMsg pulses once.
REQ-041 Hold minerBusy=1, then write CTRL=2 -> no newMsg; drop minerBusy -> newMsg within 2 cycles; STATUS bit2 reads 1 while waiting.
REQ-042 Pulse validBTC with foundNonce=32'hDEADBEEF -> NONCE reads 0xDEADBEEF and STATUS bit1=1; validBTC coinciding with CTRL=4 -> found stays 1.
REQ-043 Write CTRL=2 twice during WAIT -> exactly two newMsg pulses in total; assert rst during WAIT -> zero pulses and all outputs 0.
REQ-044 Write 0x12345678 to addr 27 without slaveChipSelect, then read addrs 27 and 3 -> both read 0 one cycle after the read strobe.
